// File: rtl/ex_vector_alu.sv
// Multi-cycle vector ALU for the execute stage: captures one vector operation,
// evaluates it LPC lanes per cycle, then pulses out_valid with result and tags.
module ex_vector_alu #(
  parameter int LANES  = 8,
  parameter int LANE_W = 32,
  parameter int LPC    = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      flush,
  input  logic [2:0]                ALUOp,
  input  logic [1:0]                SelectorOpB,
  input  logic [LANES*LANE_W-1:0]   VRS1,
  input  logic [LANES*LANE_W-1:0]   VRS2,
  input  logic [LANE_W-1:0]         RS2,
  input  logic [4:0]                RD,
  input  logic                      WRITEREGISTERVEC,
  output logic                      stall,
  output logic                      out_valid,
  output logic [LANES*LANE_W-1:0]   vresult,
  output logic [4:0]                rd_o,
  output logic                      wr_vec_o,
  output logic [1:0]                dbg_state
);

  localparam int VW    = LANES * LANE_W;
  localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int SH_W  = $clog2(LANE_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic             accept;
  logic             last_step;
  logic [IDX_W-1:0] lane_idx;
  logic [VW-1:0]    op_a;
  logic [VW-1:0]    op_b;
  logic [2:0]       op_sel;

  function automatic logic [LANE_W-1:0] lane_op(
    input logic [2:0]        op,
    input logic [LANE_W-1:0] a,
    input logic [LANE_W-1:0] b
  );
    logic [LANE_W-1:0] r;
    r = '0;
    case (op)
      3'b000:  r = a + b;
      3'b001:  r = a - b;
      3'b010:  r = a & b;
      3'b011:  r = a | b;
      3'b100:  r = a ^ b;
      3'b101:  r = a << b[SH_W-1:0];
      3'b110:  r = a >> b[SH_W-1:0];
      default: r = a * b;
    endcase
    return r;
  endfunction

  assign last_step = (lane_idx == IDX_W'(LANES - LPC));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Handshake: an operation transfers on a rising edge where in_valid=1,
  // in_ready=1 and flush=0; in_valid must stay high (stall) until then.
  always_comb begin
    state_nx  = state;
    accept    = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (!flush && in_valid) begin
          accept   = 1'b1;
          state_nx = BUSY;
        end
      end
      BUSY: begin
        if (flush) begin
          state_nx = IDLE;
        end else if (last_step) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    stall = in_valid & ~in_ready;
  end

  assign dbg_state = state;

  // Operands are captured at accept so ID/EX may move on while BUSY;
  // a flushed operation leaves its partially written vresult in place.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lane_idx <= '0;
      vresult  <= '0;
      rd_o     <= '0;
      wr_vec_o <= 1'b0;
      op_a     <= '0;
      op_b     <= '0;
      op_sel   <= '0;
    end else if (accept) begin
      lane_idx <= '0;
      vresult  <= '0;
      rd_o     <= RD;
      wr_vec_o <= WRITEREGISTERVEC;
      op_a     <= VRS1;
      op_b     <= (SelectorOpB == 2'b01) ? {LANES{RS2}} : VRS2;
      op_sel   <= ALUOp;
    end else if (state == BUSY && !flush) begin
      for (int j = 0; j < LPC; j++) begin
        vresult[(int'(lane_idx) + j) * LANE_W +: LANE_W] <=
          lane_op(op_sel, op_a[(int'(lane_idx) + j) * LANE_W +: LANE_W],
                  op_b[(int'(lane_idx) + j) * LANE_W +: LANE_W]);
      end
      lane_idx <= lane_idx + IDX_W'(LPC);
    end
  end

endmodule

// File: tb/tb_ex_vector_alu.sv
// Bench for ex_vector_alu: directed and random operations, expected results
// queued at accept time and compared by an independent output monitor.
module tb_ex_vector_alu;

  localparam int LAT = 5;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         flush = 1'b0;
  logic [2:0]   ALUOp = '0;
  logic [1:0]   SelectorOpB = '0;
  logic [255:0] VRS1 = '0;
  logic [255:0] VRS2 = '0;
  logic [31:0]  RS2 = '0;
  logic [4:0]   RD = '0;
  logic         WRITEREGISTERVEC = 1'b0;
  logic         stall;
  logic         out_valid;
  logic [255:0] vresult;
  logic [4:0]   rd_o;
  logic         wr_vec_o;
  logic [1:0]   dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // entry: {accept cycle[293:262], wr[261], rd[260:256], vresult[255:0]}
  logic [293:0] exp_q[$];
  logic [293:0] mon_e;

  ex_vector_alu dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .flush(flush), .ALUOp(ALUOp), .SelectorOpB(SelectorOpB), .VRS1(VRS1),
    .VRS2(VRS2), .RS2(RS2), .RD(RD), .WRITEREGISTERVEC(WRITEREGISTERVEC),
    .stall(stall), .out_valid(out_valid), .vresult(vresult), .rd_o(rd_o),
    .wr_vec_o(wr_vec_o), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] ref_model(input logic [2:0] op, input logic [1:0] sel,
                                             input logic [255:0] a, input logic [255:0] b,
                                             input logic [31:0] rs2);
    logic [255:0] res;
    res = '0;
    for (int i = 0; i < 8; i++) begin
      longint unsigned x, y, r;
      x = a[32*i +: 32];
      y = (sel == 2'b01) ? rs2 : b[32*i +: 32];
      case (op)
        3'd0: r = x + y;
        3'd1: r = x + (64'h1_0000_0000 - y);
        3'd2: r = x & y;
        3'd3: r = x | y;
        3'd4: r = x ^ y;
        3'd5: r = x << (y % 32);
        3'd6: r = x >> (y % 32);
        default: r = x * y;
      endcase
      res[32*i +: 32] = r[31:0];
    end
    return res;
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [255:0] splat(input logic [31:0] x);
    return {8{x}};
  endfunction

  // driver: holds in_valid until accepted, counting stall cycles
  task automatic issue(input logic [2:0] op, input logic [1:0] sel,
                       input logic [255:0] a, input logic [255:0] b,
                       input logic [31:0] rs2, input logic [4:0] rd, input logic wr,
                       input logic [255:0] exp, input bit track,
                       output int stalls, output int acc);
    int waits;
    ALUOp = op; SelectorOpB = sel; VRS1 = a; VRS2 = b; RS2 = rs2;
    RD = rd; WRITEREGISTERVEC = wr; in_valid = 1'b1;
    stalls = 0; waits = 0; acc = -1;
    #1;
    while (!in_ready && waits < 50) begin
      chk("stall_while_busy", {255'd0, stall}, 256'd1);
      stalls++; waits++;
      @(negedge clk); #1;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout actual=in_ready_low state=%0d required=in_ready_high", dbg_state);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    acc = cyc;
    if (track) exp_q.push_back({acc[31:0], wr, rd, exp});
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int waits = 0;
    while (exp_q.size() != 0 && waits < 30) begin
      @(negedge clk); waits++;
    end
    @(negedge clk);
    chk("queue_drained", 256'(exp_q.size()), 256'd0);
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (rst && out_valid) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_out_valid actual=1 required=0 vresult=%h", vresult);
      end else begin
        mon_e = exp_q.pop_front();
        chk("vresult", vresult, mon_e[255:0]);
        chk("rd_o", {251'd0, rd_o}, {251'd0, mon_e[260:256]});
        chk("wr_vec_o", {255'd0, wr_vec_o}, {255'd0, mon_e[261]});
        chk("latency", 256'(cyc - int'(mon_e[293:262]) + 1), 256'(LAT));
      end
    end
  end

  initial begin
    logic [255:0] a, b, e;
    logic [2:0] op;
    logic [1:0] sel;
    logic [31:0] s;
    int st, acc1, acc2, waits;

    // reset state, with in_valid high to see stall stays low
    in_valid = 1'b1;
    @(negedge clk); @(negedge clk);
    chk("rst_out_valid", {255'd0, out_valid}, 256'd0);
    chk("rst_vresult", vresult, 256'd0);
    chk("rst_rd_o", {251'd0, rd_o}, 256'd0);
    chk("rst_wr_vec_o", {255'd0, wr_vec_o}, 256'd0);
    chk("rst_in_ready", {255'd0, in_ready}, 256'd1);
    chk("rst_stall", {255'd0, stall}, 256'd0);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);

    // add
    for (int i = 0; i < 8; i++) begin
      a[32*i +: 32] = 32'(i + 1);
      e[32*i +: 32] = 32'(i + 32'h11);
    end
    issue(3'b000, 2'b00, a, splat(32'h10), 32'h0, 5'd5, 1'b1, e, 1'b1, st, acc1);
    // broadcast subtract wrapping below zero
    issue(3'b001, 2'b01, '0, rand256(), 32'h1, 5'd3, 1'b0, splat(32'hFFFF_FFFF), 1'b1, st, acc1);
    // shift uses only the low five bits of b
    issue(3'b101, 2'b00, splat(32'h1), splat(32'h24), 32'h0, 5'd7, 1'b1, splat(32'h10), 1'b1, st, acc1);
    issue(3'b111, 2'b00, splat(32'h10000), splat(32'h10001), 32'h0, 5'd9, 1'b1, splat(32'h0001_0000), 1'b1, st, acc1);
    drain();

    // back-to-back: second op waits, its fields differ from the in-flight one
    a = rand256(); b = rand256();
    issue(3'b100, 2'b00, a, b, 32'h0, 5'd11, 1'b1, ref_model(3'b100, 2'b00, a, b, 32'h0), 1'b1, st, acc1);
    a = rand256(); b = rand256(); s = $urandom;
    issue(3'b011, 2'b01, a, b, s, 5'd12, 1'b0, ref_model(3'b011, 2'b01, a, b, s), 1'b1, st, acc2);
    chk("stall_cycles", 256'(st), 256'd5);
    chk("second_accept_edge", 256'(acc2 - acc1), 256'd6);
    drain();

    // flush in IDLE beats in_valid
    in_valid = 1'b1; flush = 1'b1;
    @(negedge clk); @(negedge clk);
    chk("flush_idle_no_accept", {255'd0, in_ready}, 256'd1);
    in_valid = 1'b0; flush = 1'b0;
    @(negedge clk);

    // flush mid-BUSY: no pulse (monitor flags any), back to IDLE
    issue(3'b000, 2'b00, rand256(), rand256(), 32'h0, 5'd1, 1'b1, '0, 1'b0, st, acc1);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy_in_ready", {255'd0, in_ready}, 256'd1);
    chk("flush_busy_out_valid", {255'd0, out_valid}, 256'd0);
    repeat (6) @(negedge clk);

    // flush during the out_valid cycle leaves the pulse intact
    a = rand256(); b = rand256();
    issue(3'b110, 2'b00, a, b, 32'h0, 5'd20, 1'b1, ref_model(3'b110, 2'b00, a, b, 32'h0), 1'b1, st, acc1);
    waits = 0;
    while (!out_valid && waits < 20) begin
      @(negedge clk); waits++;
    end
    chk("done_pulse_seen", {255'd0, out_valid}, 256'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_done_in_ready", {255'd0, in_ready}, 256'd1);
    drain();

    // random operations, including selector codes 10/11
    for (int n = 0; n < 40; n++) begin
      op = 3'($urandom_range(0, 7));
      sel = 2'($urandom_range(0, 3));
      a = rand256(); b = rand256(); s = $urandom;
      if (op >= 3'b101 && $urandom_range(0, 1) == 1) b = b & splat(32'h0000_003F);
      issue(op, sel, a, b, s, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
            ref_model(op, sel, a, b, s), 1'b1, st, acc1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();

    // asynchronous reset mid-BUSY
    issue(3'b000, 2'b00, splat(32'h5), splat(32'h6), 32'h0, 5'd17, 1'b1, '0, 1'b0, st, acc1);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("async_out_valid", {255'd0, out_valid}, 256'd0);
    chk("async_vresult", vresult, 256'd0);
    chk("async_rd_o", {251'd0, rd_o}, 256'd0);
    chk("async_in_ready", {255'd0, in_ready}, 256'd1);
    @(negedge clk);
    rst = 1'b1;
    repeat (7) @(negedge clk);
    chk("final_queue_empty", 256'(exp_q.size()), 256'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ex_vector_alu.md
# ex_vector_alu

Multi-cycle vector ALU in the execute stage, directly downstream of the ID/EX pipeline register. It accepts one vector operation per handshake: two 256-bit vector operands, or one vector operand plus a broadcast scalar. It processes the operation as 8 lanes of 32 bits, LPC lanes per cycle. It holds the front of the pipeline stalled while busy, then presents the 256-bit result together with the destination tag for the EX/MEM register.

## Interface
- LANES, 8, number of 32-bit lanes in a vector
- LANE_W, 32, lane width in bits
- LPC, 2, lanes processed per cycle; must divide LANES (legal values 1, 2, 4, 8)

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset (0 = reset)
- in_valid  in  1  ID/EX register holds a valid vector operation
- in_ready  out  1  unit can accept a new operation
- flush  in  1  synchronous abort of any in-flight operation
- ALUOp  in  3  operation select
- SelectorOpB  in  2  00: VRS2; 01: RS2 broadcast to all lanes; 10/11: treated as 00
- VRS1  in  256  vector operand A; lane i = bits [32i+31:32i]
- VRS2  in  256  vector operand B
- RS2  in  32  scalar operand for broadcast
- RD  in  5  destination vector register
- WRITEREGISTERVEC  in  1  vector write-enable from decode
- stall  out  1  hold IF/ID and ID/EX registers
- out_valid  out  1  one-cycle pulse: result and tags are valid
- vresult  out  256  result vector
- rd_o  out  5  captured RD
- wr_vec_o  out  1  captured WRITEREGISTERVEC

## Operation
- FSM states and transitions:
  - IDLE: in_ready=1. Accept when in_valid=1 and flush=0. On accept, capture operands, ALUOp, effective OpB, RD and WRITEREGISTERVEC; clear vresult to 0; set lane_idx=0; go to BUSY.
  - BUSY: on each edge, compute lanes lane_idx..lane_idx+LPC-1, write them into vresult, and add LPC to lane_idx. After the edge that writes lane LANES-1, go to DONE.
  - DONE: out_valid=1 for exactly one cycle, then go to IDLE.
- ALUOp, per lane, with a = lane of VRS1 and b = lane of the effective OpB:
  - 000: a+b, mod 2^32
  - 001: a-b, mod 2^32
  - 010: a&b
  - 011: a|b
  - 100: a^b
  - 101: a<<b[4:0]
  - 110: a>>b[4:0], logical
  - 111: low 32 bits of a*b, unsigned
- Captured operands are held internally. ID/EX outputs may change while BUSY without effect.
- stall = in_valid & ~in_ready. An operation is not dropped while waiting.
- flush in any state forces IDLE on the next edge, with no out_valid. In IDLE, flush wins over in_valid: nothing is accepted. vresult keeps its last value.
- rd_o, wr_vec_o and vresult hold their values after DONE until the next accept.

## Timing
- Reset (rst=0, asynchronous): state IDLE, lane_idx 0, vresult 0, rd_o 0, wr_vec_o 0, out_valid 0. in_ready=1 and stall=0 while in reset, since both are decoded from state.
- K = LANES/LPC; default K=4.
- Accept at edge E0. Lanes are written on edges E1..EK. out_valid is high in the cycle after EK. The next accept is possible at edge E(K+2).
- Latency from accept edge to out_valid is K+1 cycles (default 5). Throughput is one operation per K+2 cycles.
- in_ready is low from E0 until the IDLE re-entry edge. stall follows in_valid during that window.
- A flush asserted in the same cycle as out_valid has no effect on that pulse. The FSM goes to IDLE regardless.
- Reset asserted mid-operation takes effect immediately: state IDLE, no out_valid.

## Test plan
- Add, LPC=2:
  - Stimulus: VRS1 lanes = 1..8, VRS2 lanes = 0x10 each, ALUOp=000, RD=5, WRITEREGISTERVEC=1.
  - Required: out_valid exactly 5 cycles after accept; vresult lanes = 0x11..0x18; rd_o=5; wr_vec_o=1.
- Broadcast and wrap:
  - Stimulus: ALUOp=001, VRS1 all 0, SelectorOpB=01, RS2=1.
  - Required: all lanes 0xFFFFFFFF.
- Shift and multiply:
  - Stimulus: ALUOp=101, a=0x1, b=0x24. Then ALUOp=111, a=0x10000, b=0x10001.
  - Required: shift result 0x10, since the shift amount is 4. Multiply result 0x00010000.
- Stall and hold:
  - Stimulus: hold in_valid=1 with a second operation while the first is BUSY; change the ID/EX inputs mid-operation.
  - Required: stall=1 for 5 cycles. The first result is unaffected by the input changes. The second operation is accepted at E6.
- Flush mid-BUSY:
  - Stimulus: assert flush at cycle 2 after accept.
  - Required: IDLE on the next edge; no out_valid pulse; in_ready=1.
- Async reset:
  - Stimulus: drop rst mid-BUSY, with no clock edge.
  - Required: out_valid=0, vresult=0, rd_o=0 and in_ready=1 immediately.
